// File: rtl/gray_seq_pkg.sv
// Shared state encoding and default sizing for the gray-code window sequencer.
package gray_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    FREEZE  = 3'd2,
    CAPTURE = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned CW_DEF    = 8;
  localparam int unsigned WIN_W_DEF = 16;

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module gray2bin #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] gray,
  output logic [CW-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int unsigned i = 0; i < CW; i++) begin
      acc             = acc ^ gray[CW-1-i];
      bin[CW-1-i]     = acc;
    end
  end

endmodule

// File: rtl/gray_window_sequencer.sv
// Window sequencer for ripple gray counters: runs count/freeze/capture/clear windows
// and drains the captured snapshot, one binary word per channel, over valid/ready.
module gray_window_sequencer
  import gray_seq_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CW    = CW_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF,
  localparam int unsigned CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk_master,
  input  logic               rstb,
  input  logic               enable,
  input  logic [WIN_W-1:0]   win_len,
  input  logic [N_CH*CW-1:0] gray_in,
  output logic               cnt_en,
  output logic               cnt_rstb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      out_data,
  output logic [CHW-1:0]     out_ch,
  output logic               busy,
  output logic               overrun,
  input  logic               clr_ovr
);

  state_t           state;
  state_t           state_nxt;
  logic [WIN_W-1:0] timer;
  logic [WIN_W-1:0] win_load;
  logic [CW-1:0]    snap [N_CH];
  logic [CHW-1:0]   ptr;
  logic             full;
  logic             capture;
  logic             last_ch;
  logic [CW-1:0]    sel_gray;

  always_comb begin
    win_load = (win_len == '0) ? '0 : win_len - WIN_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = COUNT;
      COUNT:   if (timer == '0) state_nxt = FREEZE;
      FREEZE:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = CLEAR;
      CLEAR:   state_nxt = enable ? COUNT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      timer    <= '0;
      cnt_en   <= 1'b0;
      cnt_rstb <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_en   <= (state_nxt == COUNT);
      cnt_rstb <= (state_nxt == COUNT) || (state_nxt == FREEZE) || (state_nxt == CAPTURE);
      busy     <= (state_nxt != IDLE);
      if (state != COUNT && state_nxt == COUNT) begin
        timer <= win_load;
      end else if (state == COUNT && timer != '0) begin
        timer <= timer - WIN_W'(1);
      end
    end
  end

  always_comb begin
    capture = (state == CAPTURE);
    last_ch = (ptr == CHW'(N_CH - 1));
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      full <= 1'b0;
      ptr  <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        snap[k] <= '0;
      end
    end else if (capture && !full) begin
      full <= 1'b1;
      ptr  <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        snap[k] <= gray_in[k*CW +: CW];
      end
    end else if (full && out_ready) begin
      ptr <= last_ch ? '0 : ptr + CHW'(1);
      if (last_ch) begin
        full <= 1'b0;
      end
    end
  end

  // A capture that finds the drain still busy wins over a same-cycle clear.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      overrun <= 1'b0;
    end else if (capture && full) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  always_comb begin
    sel_gray  = snap[ptr];
    out_valid = full;
    out_ch    = ptr;
  end

  gray2bin #(.CW(CW)) u_gray2bin (
    .gray (sel_gray),
    .bin  (out_data)
  );

endmodule

// File: doc/gray_window_sequencer.md
# gray_window_sequencer

Sequencer for a bank of ripple gray-code event counters built from gray_first_cell and its follow-on cells. It opens a counting window of programmable length by driving the counters' count-enable and reset lines, freezes and snapshots all channels at window end, clears the counters, and restarts the next window. While the next window counts, it drains the snapshot one channel at a time, converted to binary, over a valid/ready port.

## Interface
- N_CH, 4: number of counter channels (>=1)
- CW, 8: counter width in bits
- WIN_W, 16: width of window-length register

- clk_master  in  1  single clock for sequencer and counters
- rstb  in  1  asynchronous, active-low reset
- enable  in  1  run windows while high
- win_len  in  WIN_W  window length in cycles; 0 treated as 1; sampled on COUNT entry
- gray_in  in  N_CH*CW  live gray counts, channel k at [k*CW +: CW]
- cnt_en  out  1  drives counters' always1/toggle input
- cnt_rstb  out  1  active-low counter clear, registered
- out_valid  out  1  snapshot word available
- out_ready  in  1  consumer accepts word
- out_data  out  CW  binary count of channel out_ch
- out_ch  out  clog2(N_CH) (min 1)  channel index of out_data
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: snapshot dropped because drain incomplete
- clr_ovr  in  1  clears overrun (synchronous)

## Operation
- States: IDLE, COUNT, FREEZE, CAPTURE, CLEAR.
- IDLE: cnt_en=0, cnt_rstb=0 (counters held clear). enable=1 -> COUNT, timer loaded with max(win_len,1)-1.
- COUNT: cnt_en=1, cnt_rstb=1; timer decrements each cycle; timer==0 -> FREEZE. enable ignored mid-window.
- FREEZE: cnt_en=0 one cycle so ripple counters settle -> CAPTURE.
- CAPTURE: if drain empty, gray_in latched into snapshot, drain pointer=0, drain full; else snapshot kept, overrun<=1. -> CLEAR.
- CLEAR: cnt_rstb=0 one cycle. enable=1 -> COUNT (timer reloaded from win_len), else IDLE.
- Drain runs independently of FSM: out_valid=1 while drain full; out_ch=pointer; out_data=gray2bin(snapshot[pointer]). Handshake on out_valid&out_ready: pointer+1; on channel N_CH-1 drain becomes empty, out_valid drops next cycle.
- out_data/out_ch stable while out_valid&!out_ready. No combinational path out_ready -> out_valid.
- gray2bin: b[CW-1]=g[CW-1]; b[i]=b[i+1]^g[i].
- overrun: set in CAPTURE when drain full; clr_ovr clears; simultaneous set and clear -> set wins.
- Reset (any time, mid-window or mid-drain): state IDLE, timer 0, drain empty, pointer 0, snapshot 0; outputs cnt_en=0, cnt_rstb=0, out_valid=0, out_data=0, out_ch=0, busy=0, overrun=0.

## Timing
- All outputs registered except out_data (combinational from snapshot register and pointer).
- Window period with enable held: COUNT max(win_len,1) + FREEZE 1 + CAPTURE 1 + CLEAR 1 cycles.
- cnt_en falls on the edge entering FREEZE; gray_in sampled at end of CAPTURE (2 edges after cnt_en fall).
- out_valid rises the cycle after CAPTURE; with out_ready held high, N_CH words in N_CH consecutive cycles.
- Drain completes before next CAPTURE iff consumer stalls total < window period - N_CH cycles.

## Structure
- Package gray_seq_pkg: state enum (IDLE=0, COUNT, FREEZE, CAPTURE, CLEAR), default parameter constants.
- Sub-module gray2bin (parameter CW, combinational), one instance on the drain mux output.
- Snapshot as N_CH x CW register array; no memory macro.

## Test plan
- Reset mid-COUNT with out_valid high -> all outputs at reset values same cycle; cnt_rstb=0 held.
- N_CH=4, CW=8, win_len=5, gray_in ch0..3 = 0x00,0x01,0x03,0x02 at capture, out_ready=1 -> words (0,0),(1,1),(2,2),(3,3) on consecutive cycles; period 8 cycles.
- win_len=0 -> cnt_en high exactly 1 cycle per window.
- out_ready low 3 cycles on ch1 -> out_data/out_ch held stable; ch1 accepted once only.
- out_ready=0 throughout two windows -> overrun=1 at second CAPTURE, first snapshot still presented; clr_ovr pulse -> overrun=0.
- enable dropped mid-COUNT -> window completes, CLEAR then IDLE, busy=0, cnt_en=0.
